// File: rtl/mutative_burst_adapter.sv
// Burst adapter between the mutative cache dfp port and a 64-bit memory bus.
// One 256-bit line read or writeback becomes a 4-beat burst; one transaction
// is in flight at a time, and a one-cycle dfp_resp pulse marks completion.
//
// Handshake summary:
//   dfp side : dfp_read/dfp_write are held by the cache until dfp_resp; the
//              request is only sampled in IDLE, and write wins over read.
//   mem read : mem_read is a command held until mem_ready; data beats then
//              arrive on any cycle with mem_rvalid=1 (gaps allowed).
//   mem write: mem_write/mem_wdata form a valid beat held until mem_ready;
//              each cycle with mem_write && mem_ready transfers one beat.
module mutative_burst_adapter #(
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64,
  parameter int ADDR_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] dfp_addr,
  input  logic                 dfp_read,
  input  logic                 dfp_write,
  input  logic [LINE_BITS-1:0] dfp_wdata,
  output logic [LINE_BITS-1:0] dfp_rdata,
  output logic                 dfp_resp,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [BEAT_BITS-1:0] mem_wdata,
  input  logic                 mem_ready,
  input  logic [BEAT_BITS-1:0] mem_rdata,
  input  logic                 mem_rvalid,
  output logic [2:0]           fsm_state
);

  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int CW    = $clog2(BEATS);
  localparam logic [ADDR_BITS-1:0] ALIGN_MASK = ~ADDR_BITS'(LINE_BITS / 8 - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t                 state, next_state;
  logic [CW-1:0]          count;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [LINE_BITS-1:0]   wdata_q;
  logic                   last_beat;

  assign last_beat = (count == LAST_BEAT);
  assign mem_addr  = addr_q;
  assign fsm_state = state;

  // State register; reset abandons any burst without a response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state and bus outputs, all decoded from the current state.
  always_comb begin
    next_state = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_wdata  = '0;
    dfp_resp   = 1'b0;
    case (state)
      IDLE: begin
        if (dfp_write)     next_state = WR_DATA;
        else if (dfp_read) next_state = RD_REQ;
      end
      RD_REQ: begin
        mem_read = 1'b1;
        if (mem_ready) next_state = RD_DATA;
      end
      RD_DATA: begin
        if (mem_rvalid && last_beat) next_state = RESP;
      end
      WR_DATA: begin
        mem_write = 1'b1;
        mem_wdata = wdata_q[count*BEAT_BITS +: BEAT_BITS];
        if (mem_ready && last_beat) next_state = RESP;
      end
      RESP: begin
        dfp_resp   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latch, beat counter and read-line assembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      count     <= '0;
      dfp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dfp_write) begin
            addr_q  <= dfp_addr & ALIGN_MASK;
            wdata_q <= dfp_wdata;
            count   <= '0;
          end else if (dfp_read) begin
            addr_q <= dfp_addr & ALIGN_MASK;
            count  <= '0;
          end
        end
        RD_REQ: begin
          if (mem_ready) count <= '0;
        end
        RD_DATA: begin
          if (mem_rvalid) begin
            dfp_rdata[count*BEAT_BITS +: BEAT_BITS] <= mem_rdata;
            count <= count + 1'b1;
          end
        end
        WR_DATA: begin
          if (mem_ready) count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mutative_burst_adapter.sv
// Directed bench for mutative_burst_adapter. Inputs change and outputs are
// sampled on the falling edge, away from the rising active edge.
module tb_mutative_burst_adapter;

  logic         clk;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  mem_addr;
  logic         mem_read;
  logic         mem_write;
  logic [63:0]  mem_wdata;
  logic         mem_ready;
  logic [63:0]  mem_rdata;
  logic         mem_rvalid;
  logic [2:0]   fsm_state;

  localparam logic [2:0] S_IDLE = 3'd0, S_RD_REQ = 3'd1, S_RD_DATA = 3'd2,
                         S_WR_DATA = 3'd3, S_RESP = 3'd4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cmd_cyc = 0;
  int resp_cyc = 0;
  int req_c, rd0, rs0;

  mutative_burst_adapter dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .fsm_state(fsm_state)
  );

  // Clock and reset-free cycle bookkeeping.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    rd_cmd_cyc <= rd_cmd_cyc + int'(mem_read);
    resp_cyc   <= resp_cyc + int'(dfp_resp);
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one read beat for exactly one cycle.
  task automatic feed(input logic [63:0] d);
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 64'h0;
  endtask

  // Wait (bounded) until dfp_resp is seen at a falling edge.
  task automatic wait_resp(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (dfp_resp) break;
      @(negedge clk);
    end
    chk(tag, {255'd0, dfp_resp}, 256'd1);
  endtask

  logic [63:0]  b1 [4];
  logic [63:0]  w  [4];
  logic [63:0]  wexp [6];
  logic         rdy [6];
  logic         pv [7];
  logic [63:0]  g  [4];
  logic [255:0] line1, line3;
  int           gi;

  initial begin
    b1[0] = {8{8'h11}}; b1[1] = {8{8'h22}}; b1[2] = {8{8'h33}}; b1[3] = {8{8'h44}};
    w[0]  = {8{8'hD0}}; w[1]  = {8{8'hD1}}; w[2]  = {8{8'hD2}}; w[3]  = {8{8'hD3}};
    g[0]  = 64'hA0A0_0000_0000_000A; g[1] = 64'hB0B0_0000_0000_000B;
    g[2]  = 64'hC0C0_0000_0000_000C; g[3] = 64'hD0D0_0000_0000_000D;
    line1 = {b1[3], b1[2], b1[1], b1[0]};
    line3 = {g[3], g[2], g[1], g[0]};
    wexp[0] = w[0]; wexp[1] = w[1]; wexp[2] = w[1]; wexp[3] = w[1]; wexp[4] = w[2]; wexp[5] = w[3];
    rdy[0] = 1; rdy[1] = 0; rdy[2] = 0; rdy[3] = 1; rdy[4] = 1; rdy[5] = 1;
    pv[0] = 1; pv[1] = 0; pv[2] = 0; pv[3] = 1; pv[4] = 1; pv[5] = 0; pv[6] = 1;

    rst = 1'b0; dfp_addr = '0; dfp_read = 0; dfp_write = 0; dfp_wdata = '0;
    mem_ready = 0; mem_rdata = '0; mem_rvalid = 0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_state", {253'd0, fsm_state}, {253'd0, S_IDLE});
    chk("rst_resp", {255'd0, dfp_resp}, 256'd0);
    chk("rst_mem_read", {255'd0, mem_read}, 256'd0);
    chk("rst_mem_write", {255'd0, mem_write}, 256'd0);
    chk("rst_mem_addr", {224'd0, mem_addr}, 256'd0);
    chk("rst_mem_wdata", {192'd0, mem_wdata}, 256'd0);
    chk("rst_rdata", dfp_rdata, 256'd0);
    rst = 1'b1;
    @(negedge clk);

    // Read, no gaps
    dfp_addr = 32'h0000_1234; dfp_read = 1; mem_ready = 1;
    req_c = cyc; rd0 = rd_cmd_cyc; rs0 = resp_cyc;
    @(negedge clk);
    chk("rd1_state_req", {253'd0, fsm_state}, {253'd0, S_RD_REQ});
    chk("rd1_mem_read", {255'd0, mem_read}, 256'd1);
    chk("rd1_mem_addr", {224'd0, mem_addr}, {224'd0, 32'h0000_1220});
    dfp_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rd1_state_data", {253'd0, fsm_state}, {253'd0, S_RD_DATA});
    chk("rd1_mem_read_drop", {255'd0, mem_read}, 256'd0);
    for (int i = 0; i < 4; i++) feed(b1[i]);
    chk("rd1_resp", {255'd0, dfp_resp}, 256'd1);
    chk("rd1_rdata", dfp_rdata, line1);
    chk("rd1_latency", 256'(cyc - req_c), 256'd6);
    chk("rd1_cmd_cycles", 256'(rd_cmd_cyc - rd0), 256'd1);
    dfp_read = 0;
    @(negedge clk);
    chk("rd1_resp_once", {255'd0, dfp_resp}, 256'd0);
    chk("rd1_resp_count", 256'(resp_cyc - rs0), 256'd1);
    chk("rd1_idle", {253'd0, fsm_state}, {253'd0, S_IDLE});

    // Write with backpressure on beat 1
    dfp_addr = 32'h0000_1010; dfp_write = 1; dfp_wdata = {w[3], w[2], w[1], w[0]};
    mem_ready = 1; req_c = cyc;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("wr_valid_%0d", i), {255'd0, mem_write}, 256'd1);
      chk($sformatf("wr_beat_%0d", i), {192'd0, mem_wdata}, {192'd0, wexp[i]});
      if (i == 0) chk("wr_addr", {224'd0, mem_addr}, {224'd0, 32'h0000_1000});
      dfp_wdata = '1;
      mem_ready = rdy[i];
    end
    @(negedge clk);
    chk("wr_resp", {255'd0, dfp_resp}, 256'd1);
    chk("wr_mem_write_drop", {255'd0, mem_write}, 256'd0);
    chk("wr_latency", 256'(cyc - req_c), 256'd7);
    chk("wr_rdata_kept", dfp_rdata, line1);
    dfp_write = 0;
    @(negedge clk);
    chk("wr_resp_once", {255'd0, dfp_resp}, 256'd0);

    // Stray rvalid in IDLE, then read with gaps and delayed command accept
    mem_rvalid = 1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 0;
    dfp_addr = 32'h0000_2047; dfp_read = 1; mem_ready = 0;
    @(negedge clk);
    chk("rd3_cmd_wait", {255'd0, mem_read}, 256'd1);
    @(negedge clk);
    chk("rd3_cmd_held", {255'd0, mem_read}, 256'd1);
    mem_ready = 1;
    @(negedge clk);
    chk("rd3_state_data", {253'd0, fsm_state}, {253'd0, S_RD_DATA});
    gi = 0;
    for (int i = 0; i < 7; i++) begin
      mem_rvalid = pv[i];
      mem_rdata  = pv[i] ? g[gi] : 64'h0BAD_0BAD_0BAD_0BAD;
      if (pv[i]) gi++;
      @(negedge clk);
    end
    mem_rvalid = 0;
    chk("rd3_resp", {255'd0, dfp_resp}, 256'd1);
    chk("rd3_rdata", dfp_rdata, line3);
    chk("rd3_addr", {224'd0, mem_addr}, {224'd0, 32'h0000_2040});
    dfp_read = 0;
    @(negedge clk);
    dfp_addr = 32'h0000_3000; dfp_write = 1; dfp_wdata = {4{64'h5555_AAAA_5555_AAAA}}; mem_ready = 1;
    @(negedge clk);
    wait_resp("wr3_resp_seen");
    chk("wr3_rdata_kept", dfp_rdata, line3);
    dfp_write = 0;
    @(negedge clk);

    // Simultaneous read and write: write wins
    rd0 = rd_cmd_cyc;
    dfp_addr = 32'h0000_0080; dfp_read = 1; dfp_write = 1; mem_ready = 1;
    @(negedge clk);
    chk("both_state", {253'd0, fsm_state}, {253'd0, S_WR_DATA});
    chk("both_mem_write", {255'd0, mem_write}, 256'd1);
    chk("both_addr", {224'd0, mem_addr}, {224'd0, 32'h0000_0080});
    wait_resp("both_resp_seen");
    dfp_read = 0; dfp_write = 0;
    @(negedge clk);
    chk("both_no_mem_read", 256'(rd_cmd_cyc - rd0), 256'd0);

    // Back-to-back write then read, requests held through resp
    rs0 = resp_cyc; rd0 = rd_cmd_cyc;
    dfp_addr = 32'h0000_0400; dfp_write = 1; mem_ready = 1;
    @(negedge clk);
    wait_resp("b2b_wr_resp_seen");
    dfp_write = 0; dfp_read = 1; dfp_addr = 32'h0000_0500;
    @(negedge clk);
    chk("b2b_idle", {253'd0, fsm_state}, {253'd0, S_IDLE});
    chk("b2b_no_dup_write", {255'd0, mem_write}, 256'd0);
    @(negedge clk);
    chk("b2b_rd_cmd", {255'd0, mem_read}, 256'd1);
    chk("b2b_rd_addr", {224'd0, mem_addr}, {224'd0, 32'h0000_0500});
    @(negedge clk);
    for (int i = 0; i < 4; i++) feed(b1[3 - i]);
    chk("b2b_rd_resp", {255'd0, dfp_resp}, 256'd1);
    chk("b2b_rd_rdata", dfp_rdata, {b1[0], b1[1], b1[2], b1[3]});
    dfp_read = 0;
    @(negedge clk);
    chk("b2b_resp_count", 256'(resp_cyc - rs0), 256'd2);
    chk("b2b_rd_cmd_count", 256'(rd_cmd_cyc - rd0), 256'd1);

    // Reset during write beat 2
    dfp_addr = 32'h0000_0600; dfp_write = 1; dfp_wdata = {w[3], w[2], w[1], w[0]}; mem_ready = 1;
    repeat (3) @(negedge clk);
    chk("mid_beat2", {192'd0, mem_wdata}, {192'd0, w[2]});
    #2 rst = 1'b0;
    #1;
    chk("mid_state", {253'd0, fsm_state}, {253'd0, S_IDLE});
    chk("mid_mem_write", {255'd0, mem_write}, 256'd0);
    chk("mid_mem_wdata", {192'd0, mem_wdata}, 256'd0);
    chk("mid_mem_addr", {224'd0, mem_addr}, 256'd0);
    chk("mid_rdata", dfp_rdata, 256'd0);
    chk("mid_resp", {255'd0, dfp_resp}, 256'd0);
    dfp_write = 0;
    @(negedge clk);
    rst = 1'b1;
    rs0 = resp_cyc;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {253'd0, fsm_state}, {253'd0, S_IDLE});
    chk("post_rst_no_resp", 256'(resp_cyc - rs0), 256'd0);
    dfp_addr = 32'h0000_0700; dfp_read = 1;
    @(negedge clk);
    chk("post_rst_rd_cmd", {255'd0, mem_read}, 256'd1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) feed(g[i]);
    chk("post_rst_resp", {255'd0, dfp_resp}, 256'd1);
    chk("post_rst_rdata", dfp_rdata, line3);
    dfp_read = 0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #20000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mutative_burst_adapter.md
Name: mutative_burst_adapter

Overview:
Sits directly downstream of the mutative cache's dfp port and converts its single-transaction 256-bit line reads and writebacks into 64-bit, 4-beat bursts on the memory bus. It owns the beat sequencing, read-data assembly and the one-cycle dfp_resp pulse. It holds at most one transaction in flight. Flush writebacks and evictions are indistinguishable to this block.

Parameters:
LINE_BITS, 256, cacheline width on the dfp side
BEAT_BITS, 64, memory bus data width; BEATS = LINE_BITS/BEAT_BITS (4), beat counter width = $clog2(BEATS)
ADDR_BITS, 32, address width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
dfp_addr  in  32  line address from cache
dfp_read  in  1  line read request, held until dfp_resp
dfp_write  in  1  line write request, held until dfp_resp
dfp_wdata  in  256  line write data
dfp_rdata  out  256  assembled line read data
dfp_resp  out  1  one-cycle completion pulse
mem_addr  out  32  burst base address, line-aligned
mem_read  out  1  burst read command
mem_write  out  1  burst write command/beat valid
mem_wdata  out  64  write beat data
mem_ready  in  1  memory accepts read command or current write beat
mem_rdata  in  64  read beat data
mem_rvalid  in  1  read beat valid

Behaviour:
- Reset (rst=0, async): state=IDLE, beat counter=0, dfp_resp=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, dfp_rdata=0, latched addr/wdata=0. Reset mid-burst abandons the burst with no response.
- States: IDLE, RD_REQ, RD_DATA, WR_DATA, RESP.
- IDLE:
  - dfp_write=1 -> latch {dfp_addr[31:5],5'b0} and dfp_wdata; go to WR_DATA.
  - Else dfp_read=1 -> latch addr; go to RD_REQ.
  - Both asserted: write wins. The read is not queued; the cache re-presents it.
- RD_REQ: mem_read=1, mem_addr=latched addr. On mem_ready=1, go to RD_DATA with count=0. mem_read deasserts the following cycle.
- RD_DATA:
  - Each cycle with mem_rvalid=1, write mem_rdata into dfp_rdata[64*count +: 64] and increment count.
  - On the beat with count=3, go to RESP.
  - Cycles with mem_rvalid=0 are gap cycles; no state change.
- WR_DATA:
  - mem_write=1, mem_addr=latched addr, mem_wdata = latched wdata[64*count +: 64].
  - Each cycle with mem_ready=1 the beat is accepted and count increments.
  - On acceptance at count=3, go to RESP.
  - mem_ready=0 holds the current beat's data stable.
- RESP: dfp_resp=1 for exactly one cycle, then go to IDLE. No new request is sampled in RESP. The earliest new transaction is accepted in the cycle after RESP, and its command appears one cycle after that.
- dfp_rdata: registered, holds the last completed read line until the next read's beats overwrite it. It is stable during the RESP cycle. Writes do not modify it.
- Address handling: dfp_addr[4:0] is ignored. Input addr/wdata changes after latch have no effect.
- mem_rvalid outside RD_DATA is ignored. mem_ready outside RD_REQ/WR_DATA is ignored.
- Minimum latency, measured from the request sampled in IDLE to the dfp_resp cycle:
  - read: 1 (RD_REQ) + 4 beats + 1 = 6 cycles.
  - write: 4 beats + 1 = 5 cycles.
- The beat counter wraps 3->0 only on the transition to RESP.

Test Plan:
- Reset mid-burst: assert rst=0 during write beat 2 -> all outputs 0 immediately. After release, IDLE, no dfp_resp, and the next read completes normally.
- Read, no gaps: dfp_addr=0x0000_1234, mem_ready=1, rvalid beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> mem_addr=0x0000_1220, one mem_read cycle, dfp_rdata={0x44..44, 0x33..33, 0x22..22, 0x11..11}, dfp_resp high exactly 1 cycle, 6 cycles after request.
- Write with backpressure: dfp_wdata=256'h{D3,D2,D1,D0}, mem_ready low 2 cycles at beat 1 -> mem_wdata sequence D0,D1,D1,D1,D2,D3 with D1 held stable; dfp_resp once after D3 is accepted.
- Read with rvalid gaps plus stray traffic: rvalid pattern 1,0,0,1,1,0,1, and a stray rvalid while IDLE -> correct line assembled and stray beat ignored. A write issued next leaves dfp_rdata unchanged.
- Simultaneous dfp_read=1, dfp_write=1 at addr 0x80 -> write burst to 0x80 only, mem_read never asserted.
- Back-to-back: write then read, with the cache holding requests high through resp -> exactly two dfp_resp pulses, no duplicate burst. Read command issued 2 cycles after the write's resp.
